// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: fetch front-end bus bundle.
// Ports (slave = ifetch_queue side):
//   imem_addr   out  64  instruction memory address
//   imem_instr  in   32  instruction at imem_addr, same cycle
//   redirect    in   1   branch taken, flush and restart fetch
//   redirect_pc in   64  branch target (bits [1:0] ignored)
//   deq_ready   in   1   consumer takes the head entry
//   out_valid   out  1   head entry present
//   out_pc      out  64  head PC, 0 when empty
//   out_instr   out  32  head instruction, 0 when empty
//   count       out  $clog2(DEPTH)+1  occupied entries
interface ifetch_queue_if #(parameter int DEPTH = 4);
   logic [63:0]             imem_addr;
   logic [31:0]             imem_instr;
   logic                    redirect;
   logic [63:0]             redirect_pc;
   logic                    deq_ready;
   logic                    out_valid;
   logic [63:0]             out_pc;
   logic [31:0]             out_instr;
   logic [$clog2(DEPTH):0]  count;
   modport slave (
      output imem_addr, out_valid, out_pc, out_instr, count,
      input  imem_instr, redirect, redirect_pc, deq_ready
   );
   modport master (
      input  imem_addr, out_valid, out_pc, out_instr, count,
      output imem_instr, redirect, redirect_pc, deq_ready
   );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC owner plus {PC, instr} FIFO feeding IF/ID.
// Ports: clk, reset (sync, active-high), bus (ifetch_queue_if.slave).
// Optional IFQ_BRANCH_HINT_EN: follow unconditional B at fetch time.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input logic          clk,
   input logic          reset,
   ifetch_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [63:0]   fetch_pc_q, fetch_pc_d, pc_inc;
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [63:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];
   logic          empty, full, deq, enq;
   assign empty = count_q == '0;
   assign full  = count_q == CW'(DEPTH);
   assign deq   = ~empty & bus.deq_ready & ~bus.redirect;
   // a full queue still accepts a new entry when the head leaves this cycle
   assign enq   = ~bus.redirect & (~full | deq);
`ifdef IFQ_BRANCH_HINT_EN
   assign pc_inc = (bus.imem_instr[31:26] == 6'b000101) ?
                   {{36{bus.imem_instr[25]}}, bus.imem_instr[25:0], 2'b00} : 64'd4;
`else
   assign pc_inc = 64'd4;
`endif
   always_comb begin
      fetch_pc_d = bus.redirect ? (bus.redirect_pc & ~64'h3) : enq ? fetch_pc_q + pc_inc : fetch_pc_q;
      head_d     = bus.redirect ? '0 : deq ? head_q + AW'(1) : head_q;
      tail_d     = bus.redirect ? '0 : enq ? tail_q + AW'(1) : tail_q;
      count_d    = bus.redirect ? '0 : count_q + CW'(enq) - CW'(deq);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end
   // storage needs no reset: entries are only read while count is nonzero
   always_ff @(posedge clk) begin
      if (!reset && enq) begin
         pc_mem_q[tail_q]    <= fetch_pc_q;
         instr_mem_q[tail_q] <= bus.imem_instr;
      end
   end
   assign bus.imem_addr = fetch_pc_q;
   assign bus.out_valid = ~empty;
   assign bus.out_pc    = empty ? '0 : pc_mem_q[head_q];
   assign bus.out_instr = empty ? '0 : instr_mem_q[head_q];
   assign bus.count     = count_q;
endmodule
